// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: widths, ResultSrc encodings, E-stage control payload.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT      = 32;
  localparam int unsigned ALUCTRL_W_DEFAULT = 3;
  localparam int unsigned CNT_W_DEFAULT     = 16;
  localparam int unsigned REG_IDX_W         = 5;
  localparam int unsigned RESULT_SRC_W      = 2;

  typedef enum logic [RESULT_SRC_W-1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  // Single-bit and ResultSrc controls carried from decode into execute
  typedef struct packed {
    logic                    reg_write;
    logic                    mem_write;
    logic [RESULT_SRC_W-1:0] result_src;
    logic                    alu_src;
    logic                    branch;
    logic                    jump;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use interlock and branch-flush control for the fetch/decode registers.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic                    i_rst_n,
  input  logic                    i_hold_all,
  input  logic                    i_pcsrc_e,
  input  logic [RESULT_SRC_W-1:0] i_result_src_e,
  input  logic                    i_reg_write_e,
  input  logic [REG_IDX_W-1:0]    i_rd_e,
  input  logic [REG_IDX_W-1:0]    i_rs1_d,
  input  logic [REG_IDX_W-1:0]    i_rs2_d,
  output logic                    o_lu,
  output logic                    o_stall_f,
  output logic                    o_stall_d,
  output logic                    o_flush_d
);

  logic w_load_in_e;
  logic w_src_match;

  // Load in E whose destination is read by D (rs2 compared even if unused); x0 never stalls
  always_comb begin
    w_load_in_e = 1'b0;
    w_src_match = 1'b0;
    o_lu        = 1'b0;
    o_stall_f   = 1'b0;
    o_stall_d   = 1'b0;
    o_flush_d   = 1'b0;
    if (i_rst_n) begin
      w_load_in_e = (i_result_src_e == RES_LOAD) && i_reg_write_e && (i_rd_e != '0);
      w_src_match = (i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d);
      o_lu        = w_load_in_e && w_src_match;
      // A taken branch squashes D, so stalling it would only waste a cycle
      o_stall_f   = (o_lu && !i_pcsrc_e) || i_hold_all;
      o_stall_d   = o_stall_f;
      o_flush_d   = i_pcsrc_e && !i_hold_all;
    end
  end

endmodule

// File: rtl/decode_execute_stage.sv
// Decode->Execute pipeline register with hold/flush/load-use bubble priority and event counters.
module decode_execute_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEFAULT,
  parameter int unsigned ALUCTRL_W = ALUCTRL_W_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    HoldAll,
  input  logic                    PCSrcE,
  input  logic                    RegWriteD,
  input  logic                    MemWriteD,
  input  logic [RESULT_SRC_W-1:0] ResultSrcD,
  input  logic                    ALUSrcD,
  input  logic                    BranchD,
  input  logic                    JumpD,
  input  logic [ALUCTRL_W-1:0]    ALUControlD,
  input  logic [XLEN-1:0]         RD1_D,
  input  logic [XLEN-1:0]         RD2_D,
  input  logic [XLEN-1:0]         Imm_D,
  input  logic [XLEN-1:0]         PC_D,
  input  logic [XLEN-1:0]         PCPlus4_D,
  input  logic [REG_IDX_W-1:0]    Rs1_D,
  input  logic [REG_IDX_W-1:0]    Rs2_D,
  input  logic [REG_IDX_W-1:0]    RD_D,
  output logic                    RegWriteE,
  output logic                    MemWriteE,
  output logic                    ALUSrcE,
  output logic                    BranchE,
  output logic                    JumpE,
  output logic [RESULT_SRC_W-1:0] ResultSrcE,
  output logic [ALUCTRL_W-1:0]    ALUControlE,
  output logic [XLEN-1:0]         RD1_E,
  output logic [XLEN-1:0]         RD2_E,
  output logic [XLEN-1:0]         Imm_E,
  output logic [XLEN-1:0]         PC_E,
  output logic [XLEN-1:0]         PCPlus4_E,
  output logic [REG_IDX_W-1:0]    Rs1_E,
  output logic [REG_IDX_W-1:0]    Rs2_E,
  output logic [REG_IDX_W-1:0]    RD_E,
  output logic                    StallF,
  output logic                    StallD,
  output logic                    FlushD,
  output logic [CNT_W-1:0]        StallCnt,
  output logic [CNT_W-1:0]        FlushCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t                 r_ctrl_e;
  logic [ALUCTRL_W-1:0]  r_aluctrl_e;
  logic [XLEN-1:0]       r_rd1_e;
  logic [XLEN-1:0]       r_rd2_e;
  logic [XLEN-1:0]       r_imm_e;
  logic [XLEN-1:0]       r_pc_e;
  logic [XLEN-1:0]       r_pcplus4_e;
  logic [REG_IDX_W-1:0]  r_rs1_e;
  logic [REG_IDX_W-1:0]  r_rs2_e;
  logic [REG_IDX_W-1:0]  r_rd_e;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;

  ctrl_t                 w_ctrl_d;
  logic                  w_lu;
  logic                  w_bubble;

  hazard_detect u_hazard_detect (
    .i_rst_n        (rst_n),
    .i_hold_all     (HoldAll),
    .i_pcsrc_e      (PCSrcE),
    .i_result_src_e (r_ctrl_e.result_src),
    .i_reg_write_e  (r_ctrl_e.reg_write),
    .i_rd_e         (r_rd_e),
    .i_rs1_d        (Rs1_D),
    .i_rs2_d        (Rs2_D),
    .o_lu           (w_lu),
    .o_stall_f      (StallF),
    .o_stall_d      (StallD),
    .o_flush_d      (FlushD)
  );

  // Pack decoded controls and decide whether this edge inserts a bubble
  always_comb begin
    w_ctrl_d            = CTRL_BUBBLE;
    w_ctrl_d.reg_write  = RegWriteD;
    w_ctrl_d.mem_write  = MemWriteD;
    w_ctrl_d.result_src = ResultSrcD;
    w_ctrl_d.alu_src    = ALUSrcD;
    w_ctrl_d.branch     = BranchD;
    w_ctrl_d.jump       = JumpD;
    w_bubble            = PCSrcE || w_lu;
  end

  // E register: reset > hold > flush/load-use bubble > capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl_e    <= CTRL_BUBBLE;
      r_aluctrl_e <= '0;
      r_rd1_e     <= '0;
      r_rd2_e     <= '0;
      r_imm_e     <= '0;
      r_pc_e      <= '0;
      r_pcplus4_e <= '0;
      r_rs1_e     <= '0;
      r_rs2_e     <= '0;
      r_rd_e      <= '0;
    end else if (!HoldAll) begin
      if (w_bubble) begin
        r_ctrl_e    <= CTRL_BUBBLE;
        r_aluctrl_e <= '0;
        r_rd1_e     <= '0;
        r_rd2_e     <= '0;
        r_imm_e     <= '0;
        r_pc_e      <= '0;
        r_pcplus4_e <= '0;
        r_rs1_e     <= '0;
        r_rs2_e     <= '0;
        r_rd_e      <= '0;
      end else begin
        r_ctrl_e    <= w_ctrl_d;
        r_aluctrl_e <= ALUControlD;
        r_rd1_e     <= RD1_D;
        r_rd2_e     <= RD2_D;
        r_imm_e     <= Imm_D;
        r_pc_e      <= PC_D;
        r_pcplus4_e <= PCPlus4_D;
        r_rs1_e     <= Rs1_D;
        r_rs2_e     <= Rs2_D;
        r_rd_e      <= RD_D;
      end
    end
  end

  // Saturating stall/flush event counters, frozen while held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!HoldAll) begin
      if (w_lu && !PCSrcE && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (PCSrcE && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign RegWriteE   = r_ctrl_e.reg_write;
  assign MemWriteE   = r_ctrl_e.mem_write;
  assign ResultSrcE  = r_ctrl_e.result_src;
  assign ALUSrcE     = r_ctrl_e.alu_src;
  assign BranchE     = r_ctrl_e.branch;
  assign JumpE       = r_ctrl_e.jump;
  assign ALUControlE = r_aluctrl_e;
  assign RD1_E       = r_rd1_e;
  assign RD2_E       = r_rd2_e;
  assign Imm_E       = r_imm_e;
  assign PC_E        = r_pc_e;
  assign PCPlus4_E   = r_pcplus4_e;
  assign Rs1_E       = r_rs1_e;
  assign Rs2_E       = r_rs2_e;
  assign RD_E        = r_rd_e;
  assign StallCnt    = r_stall_cnt;
  assign FlushCnt    = r_flush_cnt;

endmodule

// File: tb/tb_decode_execute_stage.sv
// Bench for decode_execute_stage: per-cycle model compare plus directed literal checks.
module tb_decode_execute_stage;

  localparam int CNT_W   = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        HoldAll, PCSrcE;
  logic        RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1_D, RD2_D, Imm_D, PC_D, PCPlus4_D;
  logic [4:0]  Rs1_D, Rs2_D, RD_D;
  logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_E, PC_E, PCPlus4_E;
  logic [4:0]  Rs1_E, Rs2_E, RD_E;
  logic        StallF, StallD, FlushD;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  decode_execute_stage #(.XLEN(32), .ALUCTRL_W(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .HoldAll(HoldAll), .PCSrcE(PCSrcE),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
    .ALUSrcD(ALUSrcD), .BranchD(BranchD), .JumpD(JumpD), .ALUControlD(ALUControlD),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .Imm_D(Imm_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_D(RD_D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .BranchE(BranchE),
    .JumpE(JumpE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_E(Imm_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .RD_E(RD_E),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Model of the instruction sitting in E, as a plain record
  typedef struct {
    logic       rw, mw, alusrc, br, jmp;
    logic [1:0] rs;
    logic [2:0] aluc;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0] rs1, rs2, rd;
  } instr_t;

  instr_t m_e;
  int     m_stall_cnt, m_flush_cnt;
  bit     model_valid = 0;

  function automatic instr_t empty_instr();
    instr_t t;
    t = '{rw:0, mw:0, alusrc:0, br:0, jmp:0, rs:2'b00, aluc:3'd0,
          rd1:0, rd2:0, imm:0, pc:0, pc4:0, rs1:0, rs2:0, rd:0};
    return t;
  endfunction

  // Load in E feeding a source of D; destination x0 is never a hazard
  function automatic bit model_lu();
    return (m_e.rs == 2'b01) && m_e.rw && (m_e.rd != 0) &&
           ((m_e.rd == Rs1_D) || (m_e.rd == Rs2_D));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_e = empty_instr();
      m_stall_cnt = 0;
      m_flush_cnt = 0;
      model_valid = 1;
    end else if (!HoldAll) begin
      bit lu;
      lu = model_lu();
      if (lu && !PCSrcE) m_stall_cnt = (m_stall_cnt < CNT_SAT) ? m_stall_cnt + 1 : CNT_SAT;
      if (PCSrcE)        m_flush_cnt = (m_flush_cnt < CNT_SAT) ? m_flush_cnt + 1 : CNT_SAT;
      if (PCSrcE || lu) m_e = empty_instr();
      else m_e = '{rw:RegWriteD, mw:MemWriteD, alusrc:ALUSrcD, br:BranchD, jmp:JumpD,
                   rs:ResultSrcD, aluc:ALUControlD, rd1:RD1_D, rd2:RD2_D, imm:Imm_D,
                   pc:PC_D, pc4:PCPlus4_D, rs1:Rs1_D, rs2:Rs2_D, rd:RD_D};
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (model_valid) begin
      bit e_stall, e_flush;
      e_flush = rst_n && PCSrcE && !HoldAll;
      e_stall = rst_n && ((model_lu() && !PCSrcE) || HoldAll);
      chk("StallF", 32'(StallF), 32'(e_stall));
      chk("StallD", 32'(StallD), 32'(e_stall));
      chk("FlushD", 32'(FlushD), 32'(e_flush));
      chk("RegWriteE", 32'(RegWriteE), 32'(m_e.rw));
      chk("MemWriteE", 32'(MemWriteE), 32'(m_e.mw));
      chk("ALUSrcE", 32'(ALUSrcE), 32'(m_e.alusrc));
      chk("BranchE", 32'(BranchE), 32'(m_e.br));
      chk("JumpE", 32'(JumpE), 32'(m_e.jmp));
      chk("ResultSrcE", 32'(ResultSrcE), 32'(m_e.rs));
      chk("ALUControlE", 32'(ALUControlE), 32'(m_e.aluc));
      chk("RD1_E", RD1_E, m_e.rd1);
      chk("RD2_E", RD2_E, m_e.rd2);
      chk("Imm_E", Imm_E, m_e.imm);
      chk("PC_E", PC_E, m_e.pc);
      chk("PCPlus4_E", PCPlus4_E, m_e.pc4);
      chk("Rs1_E", 32'(Rs1_E), 32'(m_e.rs1));
      chk("Rs2_E", 32'(Rs2_E), 32'(m_e.rs2));
      chk("RD_E", 32'(RD_E), 32'(m_e.rd));
      chk("StallCnt", 32'(StallCnt), 32'(m_stall_cnt));
      chk("FlushCnt", 32'(FlushCnt), 32'(m_flush_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present a D instruction; minor controls and data derive from the tag value
  task automatic set_instr(input logic [1:0] rs, input logic rw, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] tag);
    ResultSrcD  = rs;
    RegWriteD   = rw;
    RD_D        = rd;
    Rs1_D       = rs1;
    Rs2_D       = rs2;
    RD1_D       = tag;
    RD2_D       = tag ^ 32'hA5A5_0000;
    Imm_D       = tag + 32'd1;
    PC_D        = {tag[29:0], 2'b00};
    PCPlus4_D   = {tag[29:0], 2'b00} + 32'd4;
    MemWriteD   = tag[0];
    ALUSrcD     = tag[1];
    BranchD     = tag[2];
    JumpD       = tag[3];
    ALUControlD = tag[6:4];
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; HoldAll = 1'b0; PCSrcE = 1'b0;
    set_instr(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    tick(); tick();
    chk("lit_reset_RegWriteE", 32'(RegWriteE), 32'd0);
    chk("lit_reset_StallCnt", 32'(StallCnt), 32'd0);
    chk("lit_reset_FlushCnt", 32'(FlushCnt), 32'd0);
    chk("lit_reset_StallF", 32'(StallF), 32'd0);

    // Plain capture
    rst_n = 1'b1;
    set_instr(2'b00, 1'b1, 5'd5, 5'd1, 5'd2, 32'h1234);
    @(negedge clk); chk("lit_cap_StallF", 32'(StallF), 32'd0);
    tick();
    chk("lit_cap_RD_E", 32'(RD_E), 32'd5);
    chk("lit_cap_RegWriteE", 32'(RegWriteE), 32'd1);
    chk("lit_cap_RD1_E", RD1_E, 32'h1234);

    // Load-use on rs2: lw x7 then consumer
    set_instr(2'b01, 1'b1, 5'd7, 5'd1, 5'd2, 32'h7000);
    tick();
    set_instr(2'b00, 1'b1, 5'd8, 5'd3, 5'd7, 32'h8888);
    @(negedge clk);
    chk("lit_lu_StallF", 32'(StallF), 32'd1);
    chk("lit_lu_StallD", 32'(StallD), 32'd1);
    tick();
    chk("lit_lu_bubble", 32'(RegWriteE), 32'd0);
    chk("lit_lu_StallCnt", 32'(StallCnt), 32'd1);
    @(negedge clk); chk("lit_lu_release", 32'(StallF), 32'd0);
    tick();
    chk("lit_lu_RD_E", 32'(RD_E), 32'd8);
    chk("lit_lu_RD1_E", RD1_E, 32'h8888);

    // Branch flush
    PCSrcE = 1'b1;
    set_instr(2'b00, 1'b1, 5'd9, 5'd4, 5'd5, 32'h9999);
    @(negedge clk); chk("lit_br_FlushD", 32'(FlushD), 32'd1);
    tick();
    chk("lit_br_bubble", 32'(RegWriteE), 32'd0);
    chk("lit_br_FlushCnt", 32'(FlushCnt), 32'd1);
    PCSrcE = 1'b0;

    // Flush together with load-use: flush wins
    set_instr(2'b01, 1'b1, 5'd10, 5'd0, 5'd0, 32'hAAAA);
    tick();
    set_instr(2'b00, 1'b1, 5'd11, 5'd10, 5'd1, 32'hBBBB);
    PCSrcE = 1'b1;
    @(negedge clk);
    chk("lit_brlu_StallD", 32'(StallD), 32'd0);
    chk("lit_brlu_FlushD", 32'(FlushD), 32'd1);
    tick();
    chk("lit_brlu_StallCnt", 32'(StallCnt), 32'd1);
    chk("lit_brlu_FlushCnt", 32'(FlushCnt), 32'd2);
    chk("lit_brlu_bubble", 32'(RegWriteE), 32'd0);
    PCSrcE = 1'b0;

    // Hold with pending flush
    set_instr(2'b00, 1'b1, 5'd12, 5'd1, 5'd2, 32'hC0C0);
    tick();
    HoldAll = 1'b1; PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(2'b01, 1'b1, 5'(13 + i), 5'd1, 5'd2, 32'hD000 + 32'(i));
      @(negedge clk);
      chk("lit_hold_FlushD", 32'(FlushD), 32'd0);
      chk("lit_hold_StallF", 32'(StallF), 32'd1);
      tick();
      chk("lit_hold_RD_E", 32'(RD_E), 32'd12);
      chk("lit_hold_RD1_E", RD1_E, 32'hC0C0);
      chk("lit_hold_FlushCnt", 32'(FlushCnt), 32'd2);
    end
    HoldAll = 1'b0;
    @(negedge clk); chk("lit_unhold_FlushD", 32'(FlushD), 32'd1);
    tick();
    chk("lit_unhold_bubble", 32'(RegWriteE), 32'd0);
    chk("lit_unhold_FlushCnt", 32'(FlushCnt), 32'd3);
    PCSrcE = 1'b0;

    // Load to x0 never stalls
    set_instr(2'b01, 1'b1, 5'd0, 5'd1, 5'd2, 32'hE0E0);
    tick();
    set_instr(2'b00, 1'b1, 5'd4, 5'd0, 5'd0, 32'hF0F0);
    @(negedge clk); chk("lit_x0_StallF", 32'(StallF), 32'd0);
    tick();
    chk("lit_x0_RegWriteE", 32'(RegWriteE), 32'd1);
    chk("lit_x0_RD_E", 32'(RD_E), 32'd4);

    // Reset asserted during a stall
    set_instr(2'b01, 1'b1, 5'd9, 5'd1, 5'd1, 32'h0909);
    tick();
    set_instr(2'b00, 1'b1, 5'd6, 5'd9, 5'd2, 32'h0606);
    @(negedge clk);
    chk("lit_rst_pre_StallF", 32'(StallF), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("lit_rst_RegWriteE", 32'(RegWriteE), 32'd0);
    chk("lit_rst_RD_E", 32'(RD_E), 32'd0);
    chk("lit_rst_RD1_E", RD1_E, 32'd0);
    chk("lit_rst_StallCnt", 32'(StallCnt), 32'd0);
    chk("lit_rst_FlushCnt", 32'(FlushCnt), 32'd0);
    chk("lit_rst_StallF", 32'(StallF), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("lit_rst_after_RD_E", 32'(RD_E), 32'd6);
    chk("lit_rst_after_RD1_E", RD1_E, 32'h0606);

    // Saturation: lw x3 reading x3 alternates capture / stall -> 20 stalls
    set_instr(2'b01, 1'b1, 5'd3, 5'd3, 5'd0, 32'h3333);
    repeat (40) tick();
    chk("lit_sat_StallCnt", 32'(StallCnt), 32'(CNT_SAT));
    set_instr(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
